// File: rtl/multi_clk_enable_gen.sv
// multi_clk_enable_gen: per-channel programmable refclk dividers producing ticks and square waves.
module multi_clk_enable_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = 5,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  logic [DIV_W-1:0] div [NUM_CH];
  logic [DIV_W-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] app, wrap;
  logic pending, rst_done, acc, bad;
  logic [CH_W-1:0] pend_ch;
  logic [DIV_W-1:0] pend_div, pend_phase;
  logic [LW-1:0] lock_cnt;
  assign cfg_ready = rst_done && !pending;
  assign acc = cfg_valid && cfg_ready;
  assign bad = cfg_div == '0 || cfg_phase >= cfg_div || {1'b0, cfg_ch} >= (CH_W + 1)'(NUM_CH);
  assign locked = lock_cnt == LW'(LOCK_CYCLES);
  // A pending request lands only on the target's wrap so the running period always completes.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign wrap[k] = cnt[k] == div[k] - DIV_W'(1);
    assign app[k] = pending && pend_ch == CH_W'(k) && (!ch_en[k] || wrap[k]);
  end
  always_ff @(posedge refclk)
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        div[i] <= DIV_W'(DEFAULT_DIV);
        cnt[i] <= '0;
        outclk[i] <= 1'b0;
        tick[i] <= 1'b0;
      end else begin
        outclk[i] <= ch_en[i] && cnt[i] < (div[i] >> 1) + DIV_W'(div[i][0]);
        tick[i] <= ch_en[i] && wrap[i];
        div[i] <= app[i] ? pend_div : div[i];
        cnt[i] <= !ch_en[i] ? '0 : app[i] ? pend_phase : wrap[i] ? '0 : cnt[i] + DIV_W'(1);
      end
    end
  always_ff @(posedge refclk)
    if (!rst_n) begin
      rst_done <= 1'b0;
      pending <= 1'b0;
      cfg_err <= 1'b0;
      lock_cnt <= '0;
      pend_ch <= '0;
      pend_div <= '0;
      pend_phase <= '0;
    end else begin
      rst_done <= 1'b1;
      cfg_err <= acc && bad;
      pending <= (acc && !bad) ? 1'b1 : (|app) ? 1'b0 : pending;
      pend_ch <= (acc && !bad) ? cfg_ch : pend_ch;
      pend_div <= (acc && !bad) ? cfg_div : pend_div;
      pend_phase <= (acc && !bad) ? cfg_phase : pend_phase;
      lock_cnt <= (pending || (acc && !bad)) ? '0 : locked ? lock_cnt : lock_cnt + LW'(1);
    end
endmodule

// File: tb/tb_multi_clk_enable_gen.sv
// tb_multi_clk_enable_gen: directed + random stimulus against a cycle-position reference model with a queue scoreboard.
module tb_multi_clk_enable_gen;
  localparam int LC = 16;
  logic refclk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0;
  logic [3:0] ch_en = '0;
  logic [1:0] cfg_ch = '0;
  logic [15:0] cfg_div = '0, cfg_phase = '0;
  logic cfg_ready, cfg_err, locked;
  logic [3:0] outclk, tick;
  typedef struct {bit [3:0] oc; bit [3:0] tk; bit lk; bit rd; bit er;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int m_div[4], m_age[4], m_quiet, p_ch, p_div, p_ph;
  bit m_pend, m_started;

  multi_clk_enable_gen dut (.refclk(refclk), .rst_n(rst_n), .ch_en(ch_en), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .outclk(outclk), .tick(tick), .locked(locked));

  always #5 refclk = ~refclk;

  // Model: each channel's position in its period is its age modulo its ratio.
  function automatic void model_step();
    exp_t e;
    int pos[4];
    bit acc, ok, ap;
    e = '{default: 0};
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin m_div[k] = 5; m_age[k] = 0; end
      m_pend = 0; m_started = 0; m_quiet = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        pos[k] = m_age[k] % m_div[k];
        e.oc[k] = ch_en[k] && pos[k] < (m_div[k] + 1) / 2;
        e.tk[k] = ch_en[k] && pos[k] == m_div[k] - 1;
      end
      acc = cfg_valid && m_started && !m_pend;
      ok = acc && int'(cfg_div) != 0 && int'(cfg_phase) < int'(cfg_div);
      e.er = acc && !ok;
      ap = m_pend && (!ch_en[p_ch] || pos[p_ch] == m_div[p_ch] - 1);
      for (int k = 0; k < 4; k++)
        if (ap && k == p_ch) begin
          m_div[k] = p_div;
          m_age[k] = ch_en[k] ? p_ph : 0;
        end else m_age[k] = ch_en[k] ? m_age[k] + 1 : 0;
      m_quiet = (m_pend || ok) ? 0 : m_quiet + 1;
      if (ok) begin m_pend = 1; p_ch = int'(cfg_ch); p_div = int'(cfg_div); p_ph = int'(cfg_phase); end
      else if (ap) m_pend = 0;
      m_started = 1;
      e.lk = m_quiet >= LC;
      e.rd = !m_pend;
    end
    q.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      model_step();
      @(negedge refclk);
    end
  endtask

  task automatic req(input int ch, input int dv, input int ph);
    int w = 0;
    cfg_valid = 1'b0;
    while (m_pend && w < 200) begin step(1); w++; end
    if (m_pend) begin
      checks++; errors++;
      $display("FAIL req_wait: pending never cleared after %0d cycles", w);
    end
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 16'(dv); cfg_phase = 16'(ph);
    step(1);
    cfg_valid = 1'b0;
  endtask

  function automatic void chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction

  initial forever begin
    exp_t e;
    @(posedge refclk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("outclk", int'(outclk), int'(e.oc));
      chk("tick", int'(tick), int'(e.tk));
      chk("locked", int'(locked), int'(e.lk));
      chk("cfg_ready", int'(cfg_ready), int'(e.rd));
      chk("cfg_err", int'(cfg_err), int'(e.er));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge refclk);
    rst_n = 1'b0; step(3);
    rst_n = 1'b1; ch_en = 4'hF; step(30);
    req(1, 8, 0); step(40);
    req(0, 0, 0); step(2);
    req(0, 8, 9); step(2);
    req(0, 0, 3); step(10);
    ch_en = 4'b1011; step(2);
    req(2, 3, 0); step(3);
    ch_en = 4'hF; step(20);
    req(3, 1, 0); step(10);
    req(0, 10, 7); step(40);
    req(0, 12, 0);
    rst_n = 1'b0; step(2);
    rst_n = 1'b1; step(20);
    repeat (500) begin
      if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom);
      rst_n = $urandom_range(0, 249) != 0;
      cfg_valid = $urandom_range(0, 4) == 0;
      cfg_ch = 2'($urandom);
      cfg_div = 16'($urandom_range(0, 12));
      cfg_phase = 16'($urandom_range(0, 13));
      step(1);
    end
    rst_n = 1'b1; cfg_valid = 1'b0; step(20);
    @(posedge refclk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
